// File: rtl/pueo_event_timestamp.sv
// Event timestamper: tags each enabled trigger with {period, subsec, sec, evnum} and queues it.
// Latency: trigger in cycle N is written at the edge ending N; m_ts_tvalid rises in N+1 on an empty FIFO.
// Backpressure: AXI4-Stream output; on a full FIFO with no pop that cycle, the trigger is dropped and counted.
module pueo_event_timestamp #(
   parameter int FIFO_DEPTH = 4,
   parameter     SYSCLKTYPE = "NONE"
) (
   input  logic         sys_clk_i,
   input  logic         sys_rst_i,
   input  logic         en_i,
   input  logic         trig_i,
   input  logic         pps_flag_i,
   input  logic [31:0]  cur_sec_i,
   input  logic [31:0]  cur_time_i,
   input  logic [31:0]  last_pps_i,
   input  logic [31:0]  llast_pps_i,
   output logic [127:0] m_ts_tdata,
   output logic         m_ts_tuser,
   output logic         m_ts_tvalid,
   input  logic         m_ts_tready,
   output logic [15:0]  drop_count_o,
   output logic         overflow_o,
   output logic [31:0]  evnum_o
);

   localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ENTRY_W = 129;

   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic [31:0]        evnum_q;
   logic [15:0]        drop_q;
   logic               ovf_q;
   logic [1:0]         pps_cnt;

   logic               trig_act;
   logic               full;
   logic               pop;
   logic               push;
   logic               drop;
   logic [31:0]        ent_sec;
   logic [31:0]        ent_subsec;
   logic [31:0]        ent_period;
   logic               ent_pvalid;
   logic [ENTRY_W-1:0] entry;
   logic [ENTRY_W-1:0] head;

   assign trig_act = trig_i & en_i & ~sys_rst_i;
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign pop      = m_ts_tvalid & m_ts_tready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push     = trig_act & (~full | pop);
   assign drop     = trig_act & full & ~pop;

   // Build the entry from this cycle's time inputs; a coincident PPS means the
   // second has just rolled, so the event sits at subsec 0 of the next second
   // and the period that just closed is cur_time - last_pps.
   always_comb begin
      ent_sec    = cur_sec_i;
      ent_subsec = cur_time_i - last_pps_i;
      ent_period = last_pps_i - llast_pps_i;
      if (pps_flag_i) begin
         ent_sec    = cur_sec_i + 32'd1;
         ent_subsec = 32'd0;
         ent_period = cur_time_i - last_pps_i;
      end
      ent_pvalid = (pps_cnt == 2'd2) | ((pps_cnt == 2'd1) & pps_flag_i);
      entry      = {ent_pvalid, ent_period, ent_subsec, ent_sec, evnum_q};
   end

   // Storage: only tag it as a cross-clock destination when a clock type is given.
   if (SYSCLKTYPE == "NONE") begin : g_mem_plain
      logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

      // Write the captured entry at the tail.
      always_ff @(posedge sys_clk_i) begin
         if (push) mem[wr_ptr] <= entry;
      end

      assign head = mem[rd_ptr];
   end else begin : g_mem_tagged
      (* CUSTOM_CC_DST = SYSCLKTYPE *) logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

      // Write the captured entry at the tail.
      always_ff @(posedge sys_clk_i) begin
         if (push) mem[wr_ptr] <= entry;
      end

      assign head = mem[rd_ptr];
   end

   // FIFO pointers and occupancy; reset flushes everything including a held head.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Event numbering and drop accounting; drops never consume an event number.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         evnum_q <= 32'd0;
         drop_q  <= 16'd0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) evnum_q <= evnum_q + 32'd1;
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         end
      end
   end

   // Count PPS edges since reset, saturating at two (enough to know period is real).
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         pps_cnt <= 2'd0;
      end else if (pps_flag_i && (pps_cnt != 2'd2)) begin
         pps_cnt <= pps_cnt + 2'd1;
      end
   end

   assign m_ts_tvalid  = (count != '0);
   assign m_ts_tdata   = head[127:0];
   assign m_ts_tuser   = head[128];
   assign drop_count_o = drop_q;
   assign overflow_o   = ovf_q;
   assign evnum_o      = evnum_q;

endmodule

// File: tb/tb_pueo_event_timestamp.sv
// Directed bench for pueo_event_timestamp: hand-computed entries, drop/overflow, wrap and reset cases.
module tb_pueo_event_timestamp;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         trig;
   logic         pps;
   logic [31:0]  cur_sec;
   logic [31:0]  cur_time;
   logic [31:0]  last_pps;
   logic [31:0]  llast_pps;
   logic [127:0] tdata;
   logic         tuser;
   logic         tvalid;
   logic         tready;
   logic [15:0]  drop_count;
   logic         overflow;
   logic [31:0]  evnum;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pueo_event_timestamp #(.FIFO_DEPTH(4), .SYSCLKTYPE("NONE")) dut (
      .sys_clk_i    (clk),
      .sys_rst_i    (rst),
      .en_i         (en),
      .trig_i       (trig),
      .pps_flag_i   (pps),
      .cur_sec_i    (cur_sec),
      .cur_time_i   (cur_time),
      .last_pps_i   (last_pps),
      .llast_pps_i  (llast_pps),
      .m_ts_tdata   (tdata),
      .m_ts_tuser   (tuser),
      .m_ts_tvalid  (tvalid),
      .m_ts_tready  (tready),
      .drop_count_o (drop_count),
      .overflow_o   (overflow),
      .evnum_o      (evnum)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; trig = 1'b0; pps = 1'b0; tready = 1'b0;
      cur_sec = '0; cur_time = '0; last_pps = '0; llast_pps = '0;
      tick(); tick();
      chk("rst_tvalid", 128'(tvalid), 128'd0);
      chk("rst_evnum", 128'(evnum), 128'd0);
      chk("rst_drop", 128'(drop_count), 128'd0);
      chk("rst_ovf", 128'(overflow), 128'd0);

      // Two PPS so the period is valid.
      rst = 1'b0;
      pps = 1'b1; tick(); tick(); pps = 1'b0;

      // Normal capture.
      cur_sec = 32'd5; cur_time = 32'd1000; last_pps = 32'd400; llast_pps = 32'd300;
      trig = 1'b1; tick(); trig = 1'b0;
      chk("basic_tvalid", 128'(tvalid), 128'd1);
      chk("basic_tdata", tdata, {32'd100, 32'd600, 32'd5, 32'd0});
      chk("basic_tuser", 128'(tuser), 128'd1);
      chk("basic_evnum", 128'(evnum), 128'd1);
      tick();
      chk("hold_tdata", tdata, {32'd100, 32'd600, 32'd5, 32'd0});
      chk("hold_tvalid", 128'(tvalid), 128'd1);
      tready = 1'b1; tick(); tready = 1'b0;
      chk("pop_empty", 128'(tvalid), 128'd0);

      // Coincident PPS capture.
      pps = 1'b1; trig = 1'b1;
      cur_sec = 32'd7; cur_time = 32'd2000; last_pps = 32'd1500; llast_pps = 32'd1200;
      tick(); pps = 1'b0; trig = 1'b0;
      chk("coinc_tdata", tdata, {32'd500, 32'd0, 32'd8, 32'd1});
      chk("coinc_tuser", 128'(tuser), 128'd1);
      tready = 1'b1; tick(); tready = 1'b0;

      // Disabled triggers are invisible.
      en = 1'b0; trig = 1'b1; tick(); tick(); trig = 1'b0; en = 1'b1;
      chk("dis_tvalid", 128'(tvalid), 128'd0);
      chk("dis_evnum", 128'(evnum), 128'd2);
      chk("dis_drop", 128'(drop_count), 128'd0);

      // Subsecond and event-number wrap.
      force dut.evnum_q = 32'hFFFF_FFFF;
      #1;
      release dut.evnum_q;
      cur_sec = 32'd9; cur_time = 32'h0000_0010; last_pps = 32'hFFFF_FFF0; llast_pps = 32'hFFFF_FF00;
      trig = 1'b1; tick(); trig = 1'b0;
      chk("wrap_tdata", tdata, {32'h0000_00F0, 32'h0000_0020, 32'd9, 32'hFFFF_FFFF});
      chk("wrap_evnum", 128'(evnum), 128'd0);
      tready = 1'b1; tick(); tready = 1'b0;

      // Fill past capacity with no consumer.
      rst = 1'b1; tick(); rst = 1'b0;
      cur_sec = 32'd1; cur_time = 32'd50; last_pps = 32'd20; llast_pps = 32'd10;
      trig = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      trig = 1'b0;
      chk("full_drop", 128'(drop_count), 128'd2);
      chk("full_ovf", 128'(overflow), 128'd1);
      chk("full_evnum", 128'(evnum), 128'd4);
      chk("full_head", tdata, {32'd10, 32'd30, 32'd1, 32'd0});
      chk("full_tuser", 128'(tuser), 128'd0);

      // Trigger with a pop on a full FIFO is accepted.
      trig = 1'b1; tready = 1'b1; tick(); trig = 1'b0;
      chk("fullpop_drop", 128'(drop_count), 128'd2);
      chk("fullpop_evnum", 128'(evnum), 128'd5);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("order_%0d", k), 128'(tdata[31:0]), 128'(k));
         tick();
      end
      chk("drained", 128'(tvalid), 128'd0);
      tready = 1'b0;

      // Reset with entries queued and a trigger + PPS in the reset cycle.
      trig = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      trig = 1'b0;
      chk("q3_tvalid", 128'(tvalid), 128'd1);
      rst = 1'b1; trig = 1'b1; pps = 1'b1; tick();
      rst = 1'b0; trig = 1'b0; pps = 1'b0;
      chk("rst2_tvalid", 128'(tvalid), 128'd0);
      chk("rst2_evnum", 128'(evnum), 128'd0);
      chk("rst2_drop", 128'(drop_count), 128'd0);
      chk("rst2_ovf", 128'(overflow), 128'd0);
      tick();
      chk("rst2_noentry", 128'(tvalid), 128'd0);

      // Period-valid tracking: no PPS since reset, then one plus a coincident PPS.
      trig = 1'b1; tick(); trig = 1'b0;
      chk("pv0_tdata", tdata, {32'd10, 32'd30, 32'd1, 32'd0});
      chk("pv0_tuser", 128'(tuser), 128'd0);
      tready = 1'b1; tick(); tready = 1'b0;
      pps = 1'b1; tick(); pps = 1'b0;
      cur_sec = 32'd3; cur_time = 32'd700; last_pps = 32'd600;
      pps = 1'b1; trig = 1'b1; tick(); pps = 1'b0; trig = 1'b0;
      chk("pv1_tdata", tdata, {32'd100, 32'd0, 32'd4, 32'd1});
      chk("pv1_tuser", 128'(tuser), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
